// File: rtl/im_loader_if.sv
// Bundle of the loader's control, byte-stream and instruction-memory write signals.
// master: program-download side (drives start/count/abort and the byte stream).
// slave: the loader itself (drives byte_ready, the write port and the status strobes).
interface im_loader_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32
);
    logic              start;
    logic [6:0]        word_count;
    logic              abort;
    logic [7:0]        byte_in;
    logic              byte_valid;
    logic              byte_ready;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_address;
    logic [DATA_W-1:0] wr_data;
    logic              busy;
    logic              done;
    logic              error;

    modport master (
        output start, word_count, abort, byte_in, byte_valid,
        input  byte_ready, wr_en, wr_address, wr_data, busy, done, error
    );

    modport slave (
        input  start, word_count, abort, byte_in, byte_valid,
        output byte_ready, wr_en, wr_address, wr_data, busy, done, error
    );
endinterface

// File: rtl/im_loader.sv
// Instruction-memory loader: packs a big-endian byte stream into 32-bit words, one write per word.
// Latency: write strobe one cycle after the 4th byte handshake; at best 5 cycles per word.
// Backpressure: byte_ready only in LOAD; byte_valid low simply stalls, no timeout.
module im_loader #(
    parameter int ADDR_W    = 8,
    parameter int DATA_W    = 32,
    parameter int BASE_ADDR = 0
) (
    input  logic        clk,
    input  logic        rst,
    im_loader_if.slave  bus
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [ADDR_W-1:0] BASE = ADDR_W'(BASE_ADDR);
    localparam logic [ADDR_W-1:0] STEP = ADDR_W'(4);

    state_t            state;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] word;
    logic [1:0]        byte_idx;
    logic [6:0]        remaining;
    logic              byte_ready_q;
    logic              wr_en_q;
    logic              busy_q;
    logic              done_q;
    logic              error_q;

    // FSM with registered outputs: every transition also sets the strobes for the state being entered
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            addr         <= BASE;
            word         <= '0;
            byte_idx     <= 2'd0;
            remaining    <= 7'd0;
            byte_ready_q <= 1'b0;
            wr_en_q      <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            error_q      <= 1'b0;
        end else begin
            // single-cycle strobes default low
            wr_en_q <= 1'b0;
            done_q  <= 1'b0;
            error_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        if (bus.word_count == 7'd0) begin
                            state  <= DONE;
                            done_q <= 1'b1;
                        end else if (bus.word_count > 7'd64) begin
                            error_q <= 1'b1;
                        end else begin
                            remaining    <= bus.word_count;
                            addr         <= BASE;
                            byte_idx     <= 2'd0;
                            state        <= LOAD;
                            byte_ready_q <= 1'b1;
                            busy_q       <= 1'b1;
                        end
                    end
                end
                LOAD: begin
                    if (bus.abort) begin
                        // partial word is dropped, even a byte arriving in this same cycle
                        state        <= IDLE;
                        byte_ready_q <= 1'b0;
                        busy_q       <= 1'b0;
                    end else if (bus.byte_valid) begin
                        case (byte_idx)
                            2'd0:    word[31:24] <= bus.byte_in;
                            2'd1:    word[23:16] <= bus.byte_in;
                            2'd2:    word[15:8]  <= bus.byte_in;
                            default: word[7:0]   <= bus.byte_in;
                        endcase
                        byte_idx <= byte_idx + 2'd1;
                        if (byte_idx == 2'd3) begin
                            state        <= WRITE;
                            byte_ready_q <= 1'b0;
                            wr_en_q      <= 1'b1;
                        end
                    end
                end
                WRITE: begin
                    // the write presented this cycle completes even when aborting
                    addr      <= addr + STEP;
                    remaining <= remaining - 7'd1;
                    byte_idx  <= 2'd0;
                    if (bus.abort) begin
                        state  <= IDLE;
                        busy_q <= 1'b0;
                    end else if (remaining == 7'd1) begin
                        state  <= DONE;
                        busy_q <= 1'b0;
                        done_q <= 1'b1;
                    end else begin
                        state        <= LOAD;
                        byte_ready_q <= 1'b1;
                    end
                end
                default: begin
                    state        <= IDLE;
                    byte_ready_q <= 1'b0;
                    busy_q       <= 1'b0;
                end
            endcase
        end
    end

    assign bus.byte_ready = byte_ready_q;
    assign bus.wr_en      = wr_en_q;
    assign bus.wr_address = addr;
    assign bus.wr_data    = word;
    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
    assign bus.error      = error_q;
endmodule

// File: tb/tb_im_loader.sv
// Directed bench for im_loader: two instances (base 0 and base 252) share one stimulus stream.
// A negedge monitor logs writes, handshakes and status pulses; checks compare the logs to hand values.
module tb_im_loader;
    logic clk;
    logic rst;

    im_loader_if #(.ADDR_W(8), .DATA_W(32)) b0 ();
    im_loader_if #(.ADDR_W(8), .DATA_W(32)) b1 ();

    im_loader #(.ADDR_W(8), .DATA_W(32), .BASE_ADDR(0))   u0 (.clk(clk), .rst(rst), .bus(b0));
    im_loader #(.ADDR_W(8), .DATA_W(32), .BASE_ADDR(252)) u1 (.clk(clk), .rst(rst), .bus(b1));

    assign b1.start      = b0.start;
    assign b1.word_count = b0.word_count;
    assign b1.abort      = b0.abort;
    assign b1.byte_in    = b0.byte_in;
    assign b1.byte_valid = b0.byte_valid;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // monitor logs
    logic [7:0]  wa0[$];
    logic [31:0] wd0[$];
    int          wcy0[$];
    int          whs0[$];
    logic [7:0]  wa1[$];
    logic [31:0] wd1[$];
    int hs_cnt   = 0;
    int last_hs  = 0;
    int done_cnt = 0;
    int err_cnt  = 0;
    int busy_cnt = 0;

    always @(negedge clk) begin
        if (b0.byte_valid && b0.byte_ready) begin
            hs_cnt  = hs_cnt + 1;
            last_hs = cyc;
        end
        if (b0.wr_en) begin
            wa0.push_back(b0.wr_address);
            wd0.push_back(b0.wr_data);
            wcy0.push_back(cyc);
            whs0.push_back(cyc - last_hs);
        end
        if (b1.wr_en) begin
            wa1.push_back(b1.wr_address);
            wd1.push_back(b1.wr_data);
        end
        if (b0.done)  done_cnt = done_cnt + 1;
        if (b0.error) err_cnt  = err_cnt + 1;
        if (b0.busy)  busy_cnt = busy_cnt + 1;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clr();
        wa0.delete(); wd0.delete(); wcy0.delete(); whs0.delete();
        wa1.delete(); wd1.delete();
        hs_cnt = 0; done_cnt = 0; err_cnt = 0; busy_cnt = 0;
    endtask

    task automatic start_load(input logic [6:0] n);
        b0.start      = 1'b1;
        b0.word_count = n;
        tick();
        b0.start      = 1'b0;
    endtask

    // offer one byte, wait (bounded) for byte_ready, then let it transfer; gap idle cycles after
    task automatic send_byte(input logic [7:0] d, input int gap);
        int t;
        b0.byte_in    = d;
        b0.byte_valid = 1'b1;
        t = 0;
        while (!b0.byte_ready && t < 20) begin
            tick();
            t++;
        end
        if (!b0.byte_ready) chk("byte_ready_timeout", 32'd0, 32'd1);
        tick();
        b0.byte_valid = 1'b0;
        for (int i = 0; i < gap; i++) tick();
    endtask

    task automatic send_word(input logic [31:0] w, input int gap);
        send_byte(w[31:24], gap);
        send_byte(w[23:16], gap);
        send_byte(w[15:8],  gap);
        send_byte(w[7:0],   gap);
    endtask

    task automatic check_two_words(input string pfx);
        chk({pfx, "_nwr"},   wa0.size(), 2);
        chk({pfx, "_a0"},    wa0[0], 8'h00);
        chk({pfx, "_d0"},    wd0[0], 32'h8C050014);
        chk({pfx, "_a1"},    wa0[1], 8'h04);
        chk({pfx, "_d1"},    wd0[1], 32'h8C0A0014);
        chk({pfx, "_lat0"},  whs0[0], 1);
        chk({pfx, "_lat1"},  whs0[1], 1);
        chk({pfx, "_done"},  done_cnt, 1);
    endtask

    initial begin
        rst           = 1'b1;
        b0.start      = 1'b0;
        b0.word_count = 7'd0;
        b0.abort      = 1'b0;
        b0.byte_in    = 8'h00;
        b0.byte_valid = 1'b0;
        tick(); tick();
        chk("rst_wr_en",   b0.wr_en, 0);
        chk("rst_busy",    b0.busy, 0);
        chk("rst_done",    b0.done, 0);
        chk("rst_error",   b0.error, 0);
        chk("rst_ready",   b0.byte_ready, 0);
        chk("rst_addr",    b0.wr_address, 8'h00);
        chk("rst_addr252", b1.wr_address, 8'd252);
        chk("rst_data",    b0.wr_data, 32'h0);
        rst = 1'b0;
        tick();

        // idle: toggling byte_valid does nothing
        clr();
        for (int i = 0; i < 6; i++) begin
            b0.byte_valid = i[0];
            b0.byte_in    = 8'hA5;
            tick();
        end
        b0.byte_valid = 1'b0;
        tick();
        chk("idle_hs",    hs_cnt, 0);
        chk("idle_busy",  busy_cnt, 0);
        chk("idle_wr",    wa0.size(), 0);
        chk("idle_ready", b0.byte_ready, 0);

        // two words back-to-back
        clr();
        start_load(7'd2);
        send_word(32'h8C050014, 0);
        send_word(32'h8C0A0014, 0);
        tick(); tick(); tick();
        check_two_words("b2b");
        chk("b2b_spacing", wcy0[1] - wcy0[0], 5);
        chk("b2b_idle_busy", b0.busy, 0);
        chk("wrap_nwr", wa1.size(), 2);
        chk("wrap_a0",  wa1[0], 8'd252);
        chk("wrap_a1",  wa1[1], 8'd0);
        chk("wrap_d1",  wd1[1], 32'h8C0A0014);

        // same load with 3 idle cycles between bytes
        clr();
        start_load(7'd2);
        send_word(32'h8C050014, 3);
        send_word(32'h8C0A0014, 3);
        tick(); tick(); tick();
        check_two_words("gap");

        // zero words: done without writes
        clr();
        start_load(7'd0);
        tick(); tick();
        chk("zero_done", done_cnt, 1);
        chk("zero_wr",   wa0.size(), 0);
        chk("zero_busy", busy_cnt, 0);

        // over-range count: single error pulse
        clr();
        start_load(7'd65);
        tick(); tick();
        chk("over_err",  err_cnt, 1);
        chk("over_busy", busy_cnt, 0);
        chk("over_done", done_cnt, 0);

        // abort after two bytes, with a third byte offered in the abort cycle
        clr();
        start_load(7'd1);
        send_byte(8'hAA, 0);
        send_byte(8'hBB, 0);
        b0.byte_in    = 8'h33;
        b0.byte_valid = 1'b1;
        b0.abort      = 1'b1;
        tick();
        b0.abort      = 1'b0;
        b0.byte_valid = 1'b0;
        tick(); tick(); tick();
        chk("abort_wr",    wa0.size(), 0);
        chk("abort_done",  done_cnt, 0);
        chk("abort_busy",  b0.busy, 0);
        chk("abort_ready", b0.byte_ready, 0);
        clr();
        start_load(7'd1);
        send_word(32'hDEADBEEF, 0);
        tick(); tick(); tick();
        chk("post_abort_nwr",  wa0.size(), 1);
        chk("post_abort_a",    wa0[0], 8'h00);
        chk("post_abort_d",    wd0[0], 32'hDEADBEEF);
        chk("post_abort_done", done_cnt, 1);

        // asynchronous reset in the middle of a word
        clr();
        start_load(7'd2);
        send_byte(8'h11, 0);
        send_byte(8'h22, 0);
        #2;
        rst = 1'b1;
        #1;
        chk("mid_rst_busy",  b0.busy, 0);
        chk("mid_rst_ready", b0.byte_ready, 0);
        chk("mid_rst_wr_en", b0.wr_en, 0);
        tick(); tick();
        rst = 1'b0;
        tick(); tick(); tick();
        chk("mid_rst_nwr", wa0.size(), 0);
        clr();
        start_load(7'd1);
        send_word(32'h12345678, 0);
        tick(); tick(); tick();
        chk("post_rst_nwr",  wa0.size(), 1);
        chk("post_rst_a",    wa0[0], 8'h00);
        chk("post_rst_d",    wd0[0], 32'h12345678);
        chk("post_rst_done", done_cnt, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/im_loader.md
Name: im_loader

Overview:
- Writer side of the instruction memory: accepts a byte stream (valid/ready), assembles big-endian 32-bit instruction words, and issues one write per word to the instruction memory write port.
- Word k is written at byte address BASE_ADDR + 4*k, matching the instruction memory's word spacing of 4.
- Sits between the program-download path (test harness or serial receiver) and the instruction memory, before the CPU is released from reset.

Parameters:
- ADDR_W, 8, write address width (byte-granular, word-aligned).
- DATA_W, 32, instruction word width; fixed at 4 bytes.
- BASE_ADDR, 0, address of the first word; must be a multiple of 4.

Ports:
- Clk, input, 1, rising-edge clock.
- Reset, input, 1, asynchronous, active-high reset.
- Start, input, 1, one-cycle request to begin a load; sampled only in IDLE.
- WordCount, input, 7, number of words to load (0..64); sampled with Start.
- Abort, input, 1, cancels a load in progress.
- ByteIn, input, 8, stream byte.
- ByteValid, input, 1, ByteIn is valid.
- ByteReady, output, 1, loader accepts a byte this cycle.
- WrEn, output, 1, instruction memory write strobe.
- WrAddress, output, ADDR_W, write address.
- WrData, output, DATA_W, assembled instruction word.
- Busy, output, 1, high in LOAD and WRITE.
- Done, output, 1, one-cycle pulse when a load completes.
- Error, output, 1, one-cycle pulse when a Start is rejected.

Behaviour:
- Reset (asynchronous, any state): state IDLE; ByteReady, WrEn, Busy, Done and Error all 0; WrAddress = BASE_ADDR; WrData = 0; byte index 0; remaining count 0.
- States are IDLE, LOAD, WRITE and DONE. All outputs are Moore-decoded from state or registers; no combinational path from inputs to outputs.
- IDLE:
  - Start with WordCount in 1..64: latch the count, set address to BASE_ADDR and byte index to 0, go to LOAD.
  - Start with WordCount = 0: go to DONE. No writes occur.
  - Start with WordCount > 64: Error = 1 on the next cycle, stay in IDLE.
- LOAD:
  - ByteReady = 1 and Busy = 1.
  - A byte transfers on a cycle where ByteValid and ByteReady are both high.
  - Byte order is big-endian: byte 0 goes to [31:24], byte 1 to [23:16], byte 2 to [15:8], byte 3 to [7:0].
  - The 4th transfer moves the state to WRITE on the same edge.
  - ByteValid low holds all state; there is no timeout.
- WRITE:
  - Lasts exactly one cycle. WrEn = 1, WrAddress = current address, WrData = assembled word, ByteReady = 0.
  - On exit: address += 4, modulo 2^ADDR_W (wraps 252 -> 0); remaining count -= 1; byte index is cleared.
  - Next state is DONE if the remaining count reaches 0, otherwise LOAD.
- DONE: Done = 1 for one cycle, Busy = 0, then IDLE.
- Latency and throughput:
  - WrEn asserts in the cycle immediately after the 4th byte handshake.
  - Minimum of 5 cycles per word (4 LOAD cycles plus 1 WRITE cycle).
- Outside the write cycle, WrData and WrAddress hold their last values and are don't-care to the consumer; WrEn gates them.
- Abort (synchronous):
  - In LOAD, go to IDLE on the next edge. The partial word is discarded, no write occurs, and Done does not pulse.
  - In WRITE, the write in that cycle still completes, then go to IDLE.
  - Ignored in IDLE and DONE.
  - When Abort and a byte handshake occur in the same cycle, Abort wins and the byte is dropped.
- Start outside IDLE is ignored; it causes neither Error nor a restart.
- Asynchronous Reset mid-load returns to IDLE at once. No WrEn is issued after the reset edge.

Test Plan:
- Reset then idle: all outputs 0, WrAddress = 0, ByteReady = 0; ByteValid toggling causes no state change.
- Start with WordCount = 2, bytes 8C 05 00 14 8C 0A 00 14 streamed back-to-back:
  - Write 1: WrEn at 0x00 with data 0x8C050014.
  - Write 2: WrEn at 0x04 with data 0x8C0A0014, exactly 5 cycles after write 1.
  - Done pulses once after write 2.
- The same load with ByteValid low for 3 cycles between every byte: identical write data and addresses, and each WrEn lands exactly 1 cycle after the 4th handshake.
- WordCount = 0: Done pulses with no WrEn. WordCount = 65: Error pulses for 1 cycle, no Busy.
- BASE_ADDR = 252, WordCount = 2: writes land at 252 then 0.
- Abort after 2 bytes: no WrEn, no Done, returns to IDLE. A following load of 1 word writes a clean word at BASE_ADDR.
- Reset asserted mid-word: outputs clear immediately, no further WrEn. A following load of 1 word writes a clean word at BASE_ADDR.
